// File: rtl/rgb_mode_controller_pkg.sv
// rgb_pkg: palette constants, press FSM states and palette lookup for the RGB mode controller.
package rgb_pkg;

    localparam logic [2:0] COLOR_OFF     = 3'b000;
    localparam logic [2:0] COLOR_RED     = 3'b100;
    localparam logic [2:0] COLOR_GREEN   = 3'b010;
    localparam logic [2:0] COLOR_BLUE    = 3'b001;
    localparam logic [2:0] COLOR_YELLOW  = 3'b110;
    localparam logic [2:0] COLOR_CYAN    = 3'b011;
    localparam logic [2:0] COLOR_MAGENTA = 3'b101;
    localparam logic [2:0] COLOR_WHITE   = 3'b111;

    typedef enum logic [1:0] {IDLE, PRESSED, LONG_HELD} press_state_t;

    function automatic logic [2:0] palette(input logic [2:0] idx);
        logic [2:0] rgb;
        case (idx)
            3'd1:    rgb = COLOR_RED;
            3'd2:    rgb = COLOR_GREEN;
            3'd3:    rgb = COLOR_BLUE;
            3'd4:    rgb = COLOR_YELLOW;
            3'd5:    rgb = COLOR_CYAN;
            3'd6:    rgb = COLOR_MAGENTA;
            3'd7:    rgb = COLOR_WHITE;
            default: rgb = COLOR_OFF;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/rgb_mode_controller_if.sv
// rgb_mode_controller_if: button input and mode/colour/LED outputs of the RGB controller.
interface rgb_mode_controller_if;
    logic       btn;
    logic       auto;
    logic [2:0] color_idx;
    logic       led_r;
    logic       led_g;
    logic       led_b;

    modport master (output btn, input auto, color_idx, led_r, led_g, led_b);
    modport slave  (input btn, output auto, color_idx, led_r, led_g, led_b);
endinterface

// File: rtl/rgb_mode_controller_pwm.sv
// rgb_pwm: free-running PWM counter gating the palette colour onto registered active-low LED pins.
module rgb_pwm
    import rgb_pkg::*;
#(
    parameter int PWM_BITS = 8,
    parameter int DUTY     = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] color_idx,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b
);
    localparam logic [PWM_BITS:0] DUTY_W = (PWM_BITS + 1)'(DUTY);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [2:0]          rgb;
    logic                lit;

    always_comb begin
        rgb = palette(color_idx);
        lit = {1'b0, pwm_cnt} < DUTY_W;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt               <= '0;
            {led_r, led_g, led_b} <= 3'b111;
        end else begin
            pwm_cnt               <= pwm_cnt + 1'b1;
            {led_r, led_g, led_b} <= ~(rgb & {3{lit}});
        end
    end
endmodule

// File: rtl/rgb_mode_controller.sv
// rgb_mode_controller: short press steps the palette, long press toggles timed auto-cycling.
module rgb_mode_controller
    import rgb_pkg::*;
#(
    parameter int LONG_PRESS_CYCLES = 12_000_000,
    parameter int STEP_CYCLES       = 6_000_000,
    parameter int PWM_BITS          = 8,
    parameter int DUTY              = 64
) (
    input logic                  clk,
    input logic                  rst_n,
    rgb_mode_controller_if.slave bus
);
    localparam int HW = $clog2(LONG_PRESS_CYCLES);
    localparam int SW = $clog2(STEP_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic [SW-1:0] STEP_MAX = SW'(STEP_CYCLES - 1);

    press_state_t  state;
    logic          btn_q;
    logic [HW-1:0] hold_cnt;
    logic [SW-1:0] step_cnt;
    logic          short_press;
    logic          long_press;
    logic          tick;

    always_comb begin
        short_press = (state == PRESSED) && !bus.btn;
        long_press  = (state == PRESSED) && bus.btn && (hold_cnt == HOLD_MAX);
        tick        = bus.auto && (step_cnt == STEP_MAX);
    end

    // A toggle edge never moves the colour; release and tick together advance once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            btn_q         <= 1'b0;
            hold_cnt      <= '0;
            step_cnt      <= '0;
            bus.auto      <= 1'b0;
            bus.color_idx <= '0;
        end else begin
            btn_q <= bus.btn;
            case (state)
                IDLE: if (bus.btn && !btn_q) begin
                    state    <= PRESSED;
                    hold_cnt <= '0;
                end
                PRESSED: if (!bus.btn) state <= IDLE;
                    else if (long_press) state <= LONG_HELD;
                    else hold_cnt <= hold_cnt + 1'b1;
                LONG_HELD: if (!bus.btn) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (long_press) begin
                bus.auto <= !bus.auto;
                step_cnt <= '0;
            end else begin
                if (short_press || tick) bus.color_idx <= bus.color_idx + 1'b1;
                step_cnt <= (!bus.auto || short_press || tick) ? '0 : step_cnt + 1'b1;
            end
        end
    end

    rgb_pwm #(.PWM_BITS(PWM_BITS), .DUTY(DUTY)) u_pwm (
        .clk      (clk),
        .rst_n    (rst_n),
        .color_idx(bus.color_idx),
        .led_r    (bus.led_r),
        .led_g    (bus.led_g),
        .led_b    (bus.led_b)
    );
endmodule

// File: tb/tb_rgb_mode_controller.sv
// tb_rgb_mode_controller: scoreboard bench comparing three DUTY variants against a press-age reference model.
module tb_rgb_mode_controller;
    localparam int L = 8;
    localparam int S = 16;

    typedef struct packed {
        logic       au;
        logic [2:0] idx;
        logic [2:0] la;
        logic [2:0] lb;
        logic [2:0] lc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    rgb_mode_controller_if ifa ();
    rgb_mode_controller_if ifb ();
    rgb_mode_controller_if ifc ();

    rgb_mode_controller #(.LONG_PRESS_CYCLES(L), .STEP_CYCLES(S), .PWM_BITS(2), .DUTY(4))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    rgb_mode_controller #(.LONG_PRESS_CYCLES(L), .STEP_CYCLES(S), .PWM_BITS(2), .DUTY(1))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
    rgb_mode_controller #(.LONG_PRESS_CYCLES(L), .STEP_CYCLES(S), .PWM_BITS(2), .DUTY(0))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    exp_t q[$];
    int   t;
    int   age;
    int   next_tick;
    int   m_idx;
    bit   prev;
    bit   m_auto;
    int   pal[8] = '{0, 4, 2, 1, 6, 3, 5, 7};

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] led_for(input int p, input bit lit);
        return lit ? 3'(~p) : 3'b111;
    endfunction

    task automatic model_reset();
        t = 0; age = 0; next_tick = 0; m_idx = 0; prev = 0; m_auto = 0;
        q.delete();
    endtask

    task automatic set_btn(input logic b);
        ifa.btn = b; ifb.btn = b; ifc.btn = b;
    endtask

    // Called at a falling edge: predicts the outcome of the coming rising edge.
    task automatic step(input logic b);
        exp_t e;
        int   ph;
        int   p;
        bit   short_p;
        bit   tog;
        bit   tk;
        set_btn(b);
        t++;
        ph = (t - 1) % 4;
        p  = pal[m_idx];
        e.la = led_for(p, ph < 4);
        e.lb = led_for(p, ph < 1);
        e.lc = led_for(p, ph < 0);
        short_p = 0; tog = 0;
        if (b) begin
            age = prev ? age + 1 : 1;
            if (age == L + 1) tog = 1;
        end else if (prev && age <= L) short_p = 1;
        tk = m_auto && (t == next_tick);
        if (tog) begin
            m_auto    = !m_auto;
            next_tick = t + S;
        end else if (short_p || tk) begin
            m_idx = (m_idx + 1) % 8;
            if (m_auto) next_tick = t + S;
        end
        prev  = b;
        e.au  = m_auto;
        e.idx = 3'(m_idx);
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic press(input int hi, input int lo);
        repeat (hi) step(1'b1);
        repeat (lo) step(1'b0);
    endtask

    task automatic rst_chk(input string name);
        chk({name, "_auto_a"}, {7'd0, ifa.auto}, 8'd0);
        chk({name, "_idx_a"}, {5'd0, ifa.color_idx}, 8'd0);
        chk({name, "_led_a"}, {5'd0, ifa.led_r, ifa.led_g, ifa.led_b}, 8'd7);
        chk({name, "_led_b"}, {5'd0, ifb.led_r, ifb.led_g, ifb.led_b}, 8'd7);
        chk({name, "_led_c"}, {5'd0, ifc.led_r, ifc.led_g, ifc.led_b}, 8'd7);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n && q.size() > 0) begin
                e = q.pop_front();
                chk("auto", {7'd0, ifa.auto}, {7'd0, e.au});
                chk("idx", {5'd0, ifa.color_idx}, {5'd0, e.idx});
                chk("led_d4", {5'd0, ifa.led_r, ifa.led_g, ifa.led_b}, {5'd0, e.la});
                chk("led_d1", {5'd0, ifb.led_r, ifb.led_g, ifb.led_b}, {5'd0, e.lb});
                chk("led_d0", {5'd0, ifc.led_r, ifc.led_g, ifc.led_b}, {5'd0, e.lc});
            end
        end
    end

    initial begin
        int guard;
        checks = 0; failures = 0;
        rst_n = 1'b0;
        set_btn(1'b0);
        model_reset();
        repeat (3) @(negedge clk);
        rst_chk("reset");
        rst_n = 1'b1;
        repeat (8) press(3, 2);
        press(21, 40);
        press(21, 20);
        press(8, 3);
        press(9, 3);
        press(9, 3);
        press(9, 1);
        guard = 0;
        while (next_tick != t + 4 && guard < 100) begin
            step(1'b0);
            guard++;
        end
        chk("sim_align", {7'd0, guard < 100}, 8'd1);
        press(3, 40);
        repeat (80) press($urandom_range(1, 12), $urandom_range(1, 20));
        if (!m_auto) press(9, 1);
        repeat (5) step(1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 rst_chk("async_rst");
        model_reset();
        set_btn(1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        press(3, 5);
        @(posedge clk);
        #3 chk("drain", 8'(q.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
